// File: rtl/ipsl_pcie_dma_tx_rd_sched_pkg.sv
// Shared DMA definitions for the TX read scheduler: FSM state encodings, burst
// owner encodings and the CPLD/MWR arbitration rule.
package ipsl_pcie_dma_tx_rd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } rd_sched_state_e;

    localparam logic SEL_CPLD = 1'b0;
    localparam logic SEL_MWR  = 1'b1;

    localparam int unsigned LEN_W  = 10;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned RUN_W  = 3;
    localparam int unsigned WD_W   = 16;

    // CPLD normally wins; a waiting MWR takes over once CPLD has had its run.
    function automatic logic mwr_has_priority(
        input logic             cpld_req,
        input logic             mwr_req,
        input logic [RUN_W-1:0] run_cnt,
        input logic [RUN_W-1:0] run_max
    );
        return mwr_req && (!cpld_req || (run_cnt >= run_max));
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_tx_rd_sched.sv
// Arbitrates CPLD and MWR read requests onto one shared read controller.
// Grant pulse (o_rd_en + ack) one cycle after IDLE sampling; requests held until ack.
module ipsl_pcie_dma_tx_rd_sched
    import ipsl_pcie_dma_tx_rd_sched_pkg::*;
#(
    parameter int unsigned MAX_CPLD_RUN = 4,
    parameter int unsigned TIMEOUT_CYC  = 1023
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_cpld_req,
    input  logic [LEN_W-1:0]  i_cpld_length,
    input  logic [ADDR_W-1:0] i_cpld_addr,
    output logic              o_cpld_ack,

    input  logic              i_mwr_req,
    input  logic [LEN_W-1:0]  i_mwr_length,
    input  logic [ADDR_W-1:0] i_mwr_addr,
    output logic              o_mwr_ack,

    output logic              o_rd_en,
    output logic [LEN_W-1:0]  o_rd_length,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_sel,

    input  logic              i_last_data,
    input  logic              i_tx_restart,

    output logic              o_busy,
    output logic              o_timeout
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPLD_RUN);
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TIMEOUT_CYC);

    rd_sched_state_e   state_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              rd_en_q;
    logic              cpld_ack_q;
    logic              mwr_ack_q;
    logic              timeout_q;
    logic              busy_q;
    logic              sel_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;

    logic              any_req_d;
    logic              mwr_wins_d;
    logic [WD_W-1:0]   wd_cnt_d;
    logic              wd_expired_d;
    logic [RUN_W-1:0]  run_inc_d;

    always_comb begin
        any_req_d    = i_cpld_req | i_mwr_req;
        mwr_wins_d   = mwr_has_priority(i_cpld_req, i_mwr_req, run_cnt_q, RUN_MAX);
        wd_cnt_d     = wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
        wd_expired_d = (wd_cnt_d >= WD_LIM);
        run_inc_d    = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            run_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            rd_en_q    <= 1'b0;
            cpld_ack_q <= 1'b0;
            mwr_ack_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            sel_q      <= SEL_CPLD;
            len_q      <= '0;
            addr_q     <= '0;
        end else begin
            rd_en_q    <= 1'b0;
            cpld_ack_q <= 1'b0;
            mwr_ack_q  <= 1'b0;
            timeout_q  <= 1'b0;
            // Restart beats everything, including a grant about to be issued.
            if (i_tx_restart) begin
                state_q   <= ST_IDLE;
                run_cnt_q <= '0;
                wd_cnt_q  <= '0;
                busy_q    <= 1'b0;
                sel_q     <= SEL_CPLD;
                len_q     <= '0;
                addr_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!i_mwr_req) begin
                            run_cnt_q <= '0;
                        end
                        if (any_req_d) begin
                            state_q <= ST_ISSUE;
                            busy_q  <= 1'b1;
                            if (mwr_wins_d) begin
                                sel_q     <= SEL_MWR;
                                len_q     <= i_mwr_length;
                                addr_q    <= i_mwr_addr;
                                run_cnt_q <= '0;
                            end else begin
                                sel_q  <= SEL_CPLD;
                                len_q  <= i_cpld_length;
                                addr_q <= i_cpld_addr;
                                if (i_mwr_req) begin
                                    run_cnt_q <= run_inc_d;
                                end
                            end
                        end
                    end
                    ST_ISSUE: begin
                        state_q    <= ST_BUSY;
                        rd_en_q    <= 1'b1;
                        cpld_ack_q <= (sel_q == SEL_CPLD);
                        mwr_ack_q  <= (sel_q == SEL_MWR);
                        wd_cnt_q   <= '0;
                    end
                    ST_BUSY: begin
                        // A final beat arriving on the expiry cycle still completes normally.
                        if (i_last_data) begin
                            state_q <= ST_GAP;
                        end else if (wd_expired_d) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            wd_cnt_q  <= '0;
                        end else begin
                            wd_cnt_q <= wd_cnt_d;
                        end
                    end
                    ST_GAP: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rd_en     = rd_en_q;
    assign o_cpld_ack  = cpld_ack_q;
    assign o_mwr_ack   = mwr_ack_q;
    assign o_rd_length = len_q;
    assign o_rd_addr   = addr_q;
    assign o_sel       = sel_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_tx_rd_sched.sv
// Scoreboard bench for the TX read scheduler: stimulus queues expected grants,
// a negedge monitor pops and compares whenever o_rd_en is presented.
module tb_ipsl_pcie_dma_tx_rd_sched;

    typedef struct packed {
        logic        sel;
        logic [9:0]  len;
        logic [63:0] addr;
    } grant_t;

    localparam logic [63:0] C_BASE = 64'h0000_0000_0001_0000;
    localparam logic [63:0] M_BASE = 64'h8000_0000_0000_0000;
    localparam logic [9:0]  C_LEN  = 10'h3FF;
    localparam logic [9:0]  M_LEN  = 10'd0;

    logic        clk;
    logic        rst_n;
    logic        cpld_req, mwr_req, last_data, tx_restart;
    logic [9:0]  cpld_len, mwr_len;
    logic [63:0] cpld_addr, mwr_addr;
    logic        cpld_ack, mwr_ack, rd_en, sel, busy, timeout;
    logic [9:0]  rd_len;
    logic [63:0] rd_addr;

    int     checks = 0;
    int     errors = 0;
    int     exp_to = 0;
    int     c_seq  = 0;
    int     m_seq  = 0;
    grant_t exp_q[$];
    grant_t g;

    ipsl_pcie_dma_tx_rd_sched #(.MAX_CPLD_RUN(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpld_req(cpld_req), .i_cpld_length(cpld_len), .i_cpld_addr(cpld_addr), .o_cpld_ack(cpld_ack),
        .i_mwr_req(mwr_req), .i_mwr_length(mwr_len), .i_mwr_addr(mwr_addr), .o_mwr_ack(mwr_ack),
        .o_rd_en(rd_en), .o_rd_length(rd_len), .o_rd_addr(rd_addr), .o_sel(sel),
        .i_last_data(last_data), .i_tx_restart(tx_restart),
        .o_busy(busy), .o_timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_en(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_en && n < max_cyc);
        if (!rd_en) chk("rd_en_wait_expired", {63'd0, rd_en}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, {63'd0, rd_en}, 64'd0);
        chk({tag, "_cpld_ack"}, {63'd0, cpld_ack}, 64'd0);
        chk({tag, "_mwr_ack"}, {63'd0, mwr_ack}, 64'd0);
        chk({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_sel"}, {63'd0, sel}, 64'd0);
        chk({tag, "_len"}, {54'd0, rd_len}, 64'd0);
        chk({tag, "_addr"}, rd_addr, 64'd0);
    endtask

    // Both requesters hold their level; mwr_on[k] gives the MWR level at grant k.
    task automatic run_grants(input string sels, input string mwr_on, input string tag);
        int n;
        int ci;
        int mi;
        ci = c_seq;
        mi = m_seq;
        for (int k = 0; k < sels.len(); k++) begin
            if (sels[k] == "M") begin
                exp_q.push_back(grant_t'{1'b1, M_LEN, M_BASE + 64'(mi) * 64'h80});
                mi++;
            end else begin
                exp_q.push_back(grant_t'{1'b0, C_LEN, C_BASE + 64'(ci) * 64'h40});
                ci++;
            end
        end
        cpld_len  = C_LEN;
        mwr_len   = M_LEN;
        cpld_addr = C_BASE + 64'(c_seq) * 64'h40;
        mwr_addr  = M_BASE + 64'(m_seq) * 64'h80;
        cpld_req  = 1'b1;
        mwr_req   = (mwr_on[0] == "1");
        for (int k = 0; k < sels.len(); k++) begin
            wait_rd_en(12, n);
            if (k > 0) chk({tag, "_spacing"}, 64'(n + 1), 64'd4);
            if (cpld_ack) begin
                c_seq++;
                cpld_addr = C_BASE + 64'(c_seq) * 64'h40;
            end
            if (mwr_ack) begin
                m_seq++;
                mwr_addr = M_BASE + 64'(m_seq) * 64'h80;
            end
            if (k + 1 < sels.len()) begin
                mwr_req = (mwr_on[k+1] == "1");
            end else begin
                cpld_req = 1'b0;
                mwr_req  = 1'b0;
            end
            last_data = 1'b1;
            tick();
            last_data = 1'b0;
        end
        tick();
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {63'd0, rd_en}, 64'd0);
                end else begin
                    g = exp_q.pop_front();
                    chk("grant_sel", {63'd0, sel}, {63'd0, g.sel});
                    chk("grant_len", {54'd0, rd_len}, {54'd0, g.len});
                    chk("grant_addr", rd_addr, g.addr);
                    chk("grant_acks", {62'd0, cpld_ack, mwr_ack}, {62'd0, ~g.sel, g.sel});
                end
            end else if (cpld_ack || mwr_ack) begin
                chk("ack_without_rd_en", {62'd0, cpld_ack, mwr_ack}, 64'd0);
            end
            if (timeout) begin
                if (exp_to == 0) chk("unexpected_timeout", {63'd0, timeout}, 64'd0);
                else exp_to--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst_n = 1'b1;
        cpld_req = 1'b0; mwr_req = 1'b0; last_data = 1'b0; tx_restart = 1'b0;
        cpld_len = '0; mwr_len = '0; cpld_addr = '0; mwr_addr = '0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Scenario 1: single CPLD burst, last beat five cycles after the grant.
        cpld_req = 1'b1; cpld_len = 10'd16; cpld_addr = 64'h100;
        exp_q.push_back(grant_t'{1'b0, 10'd16, 64'h100});
        tick();
        chk("s1_no_rd_en_at_sample", {63'd0, rd_en}, 64'd0);
        chk("s1_busy_issue", {63'd0, busy}, 64'd1);
        tick();
        chk("s1_rd_en", {63'd0, rd_en}, 64'd1);
        chk("s1_cpld_ack", {63'd0, cpld_ack}, 64'd1);
        cpld_req = 1'b0;
        tick();
        chk("s1_rd_en_one_cycle", {63'd0, rd_en}, 64'd0);
        chk("s1_ack_one_cycle", {63'd0, cpld_ack}, 64'd0);
        repeat (3) tick();
        last_data = 1'b1;
        tick();
        last_data = 1'b0;
        chk("s1_busy_gap", {63'd0, busy}, 64'd1);
        chk("s1_len_held", {54'd0, rd_len}, 64'd16);
        tick();
        chk("s1_idle", {63'd0, busy}, 64'd0);
        chk("s1_addr_held", rd_addr, 64'h100);

        // Scenario 2: fairness run, then MWR withdrawal clearing the run count.
        run_grants("CCCCMCCCCM", "1111111111", "s2");
        run_grants("CCCCCCCCM", "111011111", "s2b");

        // Scenario 3: restart while the grant is being issued.
        mwr_req = 1'b1; mwr_len = 10'd33; mwr_addr = 64'hDEAD_BEEF_0000_0040;
        tick();
        tx_restart = 1'b1;
        tick();
        tx_restart = 1'b0;
        check_all_zero("s3_restart");
        exp_q.push_back(grant_t'{1'b1, 10'd33, 64'hDEAD_BEEF_0000_0040});
        tick();
        chk("s3_no_rd_en_at_sample", {63'd0, rd_en}, 64'd0);
        tick();
        chk("s3_regrant", {63'd0, rd_en}, 64'd1);
        mwr_req = 1'b0;
        last_data = 1'b1;
        tick();
        last_data = 1'b0;
        tick();

        // Scenario 4: watchdog expiry with no final beat.
        cpld_req = 1'b1; cpld_len = 10'd5; cpld_addr = 64'h3000;
        exp_q.push_back(grant_t'{1'b0, 10'd5, 64'h3000});
        wait_rd_en(4, n);
        chk("s4_latency", 64'(n), 64'd2);
        cpld_req = 1'b0;
        exp_to = 1;
        repeat (7) tick();
        chk("s4_no_timeout_early", {63'd0, timeout}, 64'd0);
        chk("s4_busy_before", {63'd0, busy}, 64'd1);
        tick();
        chk("s4_timeout", {63'd0, timeout}, 64'd1);
        chk("s4_idle_at_timeout", {63'd0, busy}, 64'd0);
        tick();
        chk("s4_timeout_one_cycle", {63'd0, timeout}, 64'd0);
        chk("s4_no_reissue", {62'd0, rd_en, cpld_ack}, 64'd0);

        // Scenario 5: final beat on the expiry cycle; last_data in ISSUE ignored.
        cpld_req = 1'b1; cpld_len = 10'd3; cpld_addr = 64'h5000;
        exp_q.push_back(grant_t'{1'b0, 10'd3, 64'h5000});
        tick();
        last_data = 1'b1;
        tick();
        last_data = 1'b0;
        cpld_req = 1'b0;
        chk("s5_rd_en", {63'd0, rd_en}, 64'd1);
        repeat (7) tick();
        chk("s5_still_busy", {63'd0, busy}, 64'd1);
        last_data = 1'b1;
        tick();
        last_data = 1'b0;
        chk("s5_no_timeout", {63'd0, timeout}, 64'd0);
        chk("s5_gap", {63'd0, busy}, 64'd1);
        tick();
        chk("s5_idle", {63'd0, busy}, 64'd0);
        chk("s5_timeout_low", {63'd0, timeout}, 64'd0);

        // Scenario 6: asynchronous reset mid-burst, then first grant after release.
        mwr_req = 1'b1; mwr_len = 10'd100; mwr_addr = 64'hABC0;
        exp_q.push_back(grant_t'{1'b1, 10'd100, 64'hABC0});
        wait_rd_en(4, n);
        mwr_req = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6_async_reset");
        cpld_req = 1'b1; cpld_len = 10'd9; cpld_addr = 64'h4000;
        tick();
        tick();
        chk("s6_held_in_reset", {62'd0, rd_en, busy}, 64'd0);
        rst_n = 1'b1;
        exp_q.push_back(grant_t'{1'b0, 10'd9, 64'h4000});
        tick();
        chk("s6_no_grant_first_edge", {63'd0, rd_en}, 64'd0);
        tick();
        chk("s6_grant_second_edge", {63'd0, rd_en}, 64'd1);
        cpld_req = 1'b0;
        last_data = 1'b1;
        tick();
        last_data = 1'b0;
        tick();
        chk("s6_idle", {63'd0, busy}, 64'd0);

        tick();
        chk("grant_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("timeouts_outstanding", 64'(exp_to), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
